// File: rtl/cnn_buf_pkg.sv
// Shared types and helpers for the CNN staging buffers.
// Bank state encoding, bank count and a width helper used by the RAM and ping-pong logic.
package cnn_buf_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  localparam int unsigned NUM_BANKS = 2;

  // Address width for n entries, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Simple dual-port block RAM: one write port, one registered read port.
// The read register clears on reset and holds its value when no read is issued.
module sdp_ram_core
  import cnn_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = clog2_min1(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pingpong_bram_wc.sv
// Double-buffered width-converting buffer: narrow words are packed into wide words of one bank
// while the consumer randomly reads the other bank; banks are handed over by close/release.
module pingpong_bram_wc
  import cnn_buf_pkg::*;
#(
  parameter int unsigned WR_BW    = 32,
  parameter int unsigned RATIO    = 2,
  parameter int unsigned RD_DEPTH = 8,
  parameter int unsigned RD_AW    = clog2_min1(RD_DEPTH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_VALID,
  output logic                     WR_READY,
  input  logic [WR_BW-1:0]         WR_DATA,
  input  logic                     WR_LAST,
  input  logic                     RD_EN,
  input  logic [RD_AW-1:0]         RD_ADDR,
  output logic [WR_BW*RATIO-1:0]   RD_DATA,
  output logic                     RD_VALID,
  output logic                     BANK_RDY,
  output logic [RD_AW:0]           RD_LEN,
  input  logic                     RD_DONE,
  output logic                     WR_BANK,
  output logic                     RD_BANK
);

  localparam int unsigned LSH    = $clog2(RATIO);
  localparam int unsigned WIDX_W = RD_AW + LSH;
  localparam int unsigned LANE_W = clog2_min1(RATIO);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(RD_DEPTH * RATIO - 1);

  bank_state_e       state_q [NUM_BANKS];
  bank_state_e       state_d [NUM_BANKS];
  logic [RD_AW:0]    len_q   [NUM_BANKS];
  logic [RD_AW:0]    len_d   [NUM_BANKS];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic              rd_valid_q;

  logic              wr_xfer, wr_close, rd_fire, rd_rel;
  logic [RD_AW-1:0]  wr_addr;
  logic [LANE_W-1:0] wr_lane;

  assign WR_READY = (state_q[wr_bank_q] == BANK_EMPTY);
  assign BANK_RDY = (state_q[rd_bank_q] == BANK_FULL);
  assign RD_LEN   = BANK_RDY ? len_q[rd_bank_q] : '0;
  assign RD_VALID = rd_valid_q;
  assign WR_BANK  = wr_bank_q;
  assign RD_BANK  = rd_bank_q;

  assign wr_xfer  = WR_VALID & WR_READY;
  assign wr_close = wr_xfer & ((widx_q == WIDX_LAST) | WR_LAST);
  assign rd_fire  = RD_EN & BANK_RDY;
  assign rd_rel   = RD_DONE & BANK_RDY;
  assign wr_addr  = RD_AW'(widx_q >> LSH);

  if (RATIO > 1) begin : g_lane_sel
    assign wr_lane = widx_q[LANE_W-1:0];
  end else begin : g_lane_zero
    assign wr_lane = '0;
  end

  // A close always hits an EMPTY bank and a release a FULL one, so they never collide.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    widx_d    = widx_q;
    if (wr_xfer) begin
      widx_d = widx_q + WIDX_W'(1);
      if (wr_close) begin
        state_d[wr_bank_q] = BANK_FULL;
        len_d[wr_bank_q]   = {1'b0, wr_addr} + (RD_AW + 1)'(1);
        wr_bank_d          = ~wr_bank_q;
        widx_d             = '0;
      end
    end
    if (rd_rel) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= BANK_EMPTY;
        len_q[b]   <= '0;
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      widx_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      widx_q     <= widx_d;
      rd_valid_q <= rd_fire;
    end
  end

  // One RAM per lane; the bank index is the address MSB.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    sdp_ram_core #(
      .WIDTH (WR_BW),
      .DEPTH (NUM_BANKS * RD_DEPTH)
    ) u_ram (
      .CLK   (CLK),
      .RST   (RST),
      .we    (wr_xfer && (wr_lane == LANE_W'(i))),
      .waddr ({wr_bank_q, wr_addr}),
      .wdata (WR_DATA),
      .re    (rd_fire),
      .raddr ({rd_bank_q, RD_ADDR}),
      .rdata (RD_DATA[i*WR_BW +: WR_BW])
    );
  end

endmodule

// File: tb/tb_pingpong_bram_wc.sv
// Self-checking bench for pingpong_bram_wc: a bank/memory model feeds a read-data scoreboard,
// status outputs are compared directly. Inputs change and outputs are sampled on negedge.
module tb_pingpong_bram_wc;

  logic        CLK, RST;
  logic        WR_VALID, WR_READY, WR_LAST;
  logic [31:0] WR_DATA;
  logic        RD_EN, RD_VALID, BANK_RDY, RD_DONE, WR_BANK, RD_BANK;
  logic [2:0]  RD_ADDR;
  logic [63:0] RD_DATA;
  logic [3:0]  RD_LEN;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb [$];
  logic [63:0] mdl [2][8];
  int          m_widx;
  bit          m_wbank, m_rbank;
  logic [63:0] last_rd;

  pingpong_bram_wc #(
    .WR_BW    (32),
    .RATIO    (2),
    .RD_DEPTH (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .WR_DATA  (WR_DATA),
    .WR_LAST  (WR_LAST),
    .RD_EN    (RD_EN),
    .RD_ADDR  (RD_ADDR),
    .RD_DATA  (RD_DATA),
    .RD_VALID (RD_VALID),
    .BANK_RDY (BANK_RDY),
    .RD_LEN   (RD_LEN),
    .RD_DONE  (RD_DONE),
    .WR_BANK  (WR_BANK),
    .RD_BANK  (RD_BANK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every RD_VALID must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RD_VALID) begin
      if (sb.size() == 0) check_eq("rd_spurious", 64'(RD_VALID), 64'd0);
      else check_eq("rd_data", RD_DATA, sb.pop_front());
    end
  end

  // Called on a negedge; returns on the negedge after the transfer.
  task automatic wr(input logic [31:0] d, input bit last);
    int n;
    n = 0;
    WR_VALID = 1'b1;
    WR_DATA  = d;
    WR_LAST  = last;
    while (!WR_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("wr_ready", 64'(WR_READY), 64'd1);
    @(negedge CLK);
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
    mdl[m_wbank][m_widx / 2][(m_widx % 2) * 32 +: 32] = d;
    if (m_widx == 15 || last) begin
      m_wbank = !m_wbank;
      m_widx  = 0;
    end else begin
      m_widx++;
    end
  endtask

  task automatic fill(input logic [31:0] base, input int n, input bit close_early);
    for (int k = 0; k < n; k++) wr(base + 32'(k), close_early && (k == n - 1));
  endtask

  task automatic rd(input logic [2:0] a);
    RD_EN   = 1'b1;
    RD_ADDR = a;
    last_rd = mdl[m_rbank][a];
    sb.push_back(last_rd);
    @(negedge CLK);
    RD_EN = 1'b0;
  endtask

  task automatic rd_all();
    for (int i = 0; i < 8; i++) rd(3'(i));
  endtask

  task automatic release_bank();
    RD_DONE = 1'b1;
    @(negedge CLK);
    RD_DONE = 1'b0;
    m_rbank = !m_rbank;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < 8; a++) mdl[b][a] = '0;
    m_widx = 0; m_wbank = 0; m_rbank = 0; last_rd = '0;
    RST = 1'b1; WR_VALID = 0; WR_DATA = '0; WR_LAST = 0;
    RD_EN = 0; RD_ADDR = '0; RD_DONE = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_eq("rst_wr_ready", 64'(WR_READY), 64'd1);
    check_eq("rst_bank_rdy", 64'(BANK_RDY), 64'd0);
    check_eq("rst_rd_len", 64'(RD_LEN), 64'd0);
    check_eq("rst_rd_valid", 64'(RD_VALID), 64'd0);
    check_eq("rst_rd_data", RD_DATA, 64'd0);
    check_eq("rst_banks", 64'({WR_BANK, RD_BANK}), 64'd0);

    // T1: full fill of bank 0 then read back
    fill(32'h0, 16, 1'b0);
    check_eq("t1_bank_rdy", 64'(BANK_RDY), 64'd1);
    check_eq("t1_rd_len", 64'(RD_LEN), 64'd8);
    check_eq("t1_wr_bank", 64'(WR_BANK), 64'd1);
    check_eq("t1_addr3_model", mdl[0][3], 64'h00000007_00000006);
    rd_all();

    // T2: fill bank 1 while reading bank 0, then read+release together
    fork
      fill(32'h100, 16, 1'b0);
      rd_all();
    join
    RD_EN = 1'b1; RD_ADDR = 3'd5; RD_DONE = 1'b1;
    last_rd = mdl[m_rbank][5];
    sb.push_back(last_rd);
    @(negedge CLK);
    RD_EN = 1'b0; RD_DONE = 1'b0; m_rbank = !m_rbank;
    check_eq("t2_rd_bank", 64'(RD_BANK), 64'd1);
    check_eq("t2_bank_rdy", 64'(BANK_RDY), 64'd1);
    check_eq("t2_rd_len", 64'(RD_LEN), 64'd8);
    check_eq("t2_wr_ready", 64'(WR_READY), 64'd1);
    rd_all();

    // T4: both banks full, stalled writes must not land
    fill(32'h200, 16, 1'b0);
    check_eq("t4_wr_ready_full", 64'(WR_READY), 64'd0);
    WR_VALID = 1'b1; WR_DATA = 32'hDEAD_BEEF;
    repeat (10) @(negedge CLK);
    check_eq("t4_wr_ready_hold", 64'(WR_READY), 64'd0);
    check_eq("t4_wr_bank_hold", 64'(WR_BANK), 64'd1);
    WR_VALID = 1'b0;
    release_bank();
    check_eq("t4_wr_ready_rel", 64'(WR_READY), 64'd1);
    check_eq("t4_rd_bank", 64'(RD_BANK), 64'd0);
    rd_all();
    release_bank();

    // T3: early close after 5 words into bank 1 (widx must have stayed at 0)
    fill(32'h300, 5, 1'b1);
    check_eq("t3_bank_rdy", 64'(BANK_RDY), 64'd1);
    check_eq("t3_rd_len", 64'(RD_LEN), 64'd3);
    check_eq("t3_addr2_lane0_model", 64'(mdl[1][2][31:0]), 64'h304);
    rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd5);
    release_bank();

    // T5: read/release requests against an empty bank are ignored
    RD_EN = 1'b1; RD_DONE = 1'b1; RD_ADDR = 3'd1;
    repeat (2) @(negedge CLK);
    RD_EN = 1'b0; RD_DONE = 1'b0;
    check_eq("t5_rd_valid", 64'(RD_VALID), 64'd0);
    check_eq("t5_rd_bank", 64'(RD_BANK), 64'd0);
    check_eq("t5_bank_rdy", 64'(BANK_RDY), 64'd0);
    check_eq("t5_rd_data_hold", RD_DATA, last_rd);

    // T6: asynchronous reset between edges in the middle of a fill
    fill(32'h400, 16, 1'b0);
    fill(32'h480, 7, 1'b0);
    check_eq("t6_pre_bank_rdy", 64'(BANK_RDY), 64'd1);
    #2 RST = 1'b1;
    #1;
    check_eq("t6_wr_ready", 64'(WR_READY), 64'd1);
    check_eq("t6_bank_rdy", 64'(BANK_RDY), 64'd0);
    check_eq("t6_rd_len", 64'(RD_LEN), 64'd0);
    check_eq("t6_banks", 64'({WR_BANK, RD_BANK}), 64'd0);
    check_eq("t6_rd_data", RD_DATA, 64'd0);
    check_eq("t6_rd_valid", 64'(RD_VALID), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    m_wbank = 0; m_rbank = 0; m_widx = 0;
    fill(32'h500, 16, 1'b0);
    check_eq("t6_refill_len", 64'(RD_LEN), 64'd8);
    rd_all();

    repeat (3) @(negedge CLK);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
